// File: rtl/vend_pkg.sv
// Shared types for the multi-product vending controller: FSM state encoding,
// coin-acceptor codes and coin-to-unit conversion.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_REFUND = 2'd2
    } state_e;

    localparam logic [1:0] COIN_NONE   = 2'd0;
    localparam logic [1:0] COIN_1      = 2'd1;
    localparam logic [1:0] COIN_2      = 2'd2;
    localparam logic [1:0] COIN_CANCEL = 2'd3;

    // Cancel carries no value; it is handled as a separate request.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_1:  coin_units = 2'd1;
            COIN_2:  coin_units = 2'd2;
            default: coin_units = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters: saturating decrement, global restock (wins over a
// same-edge decrement) and per-item empty flags.
module vend_stock
    import vend_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10,
    parameter int SEL_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dec_valid,
    input  logic [SEL_W-1:0]   dec_idx,
    input  logic               restock,
    output logic [N_ITEMS-1:0] empty
);

    logic [STOCK_W-1:0] count [N_ITEMS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ITEMS; i++) count[i] <= STOCK_W'(STOCK_INIT);
        end else if (restock) begin
            for (int i = 0; i < N_ITEMS; i++) count[i] <= STOCK_W'(STOCK_INIT);
        end else if (dec_valid && (32'(dec_idx) < 32'(N_ITEMS))) begin
            if (count[dec_idx] != '0) count[dec_idx] <= count[dec_idx] - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) empty[i] = (count[i] == '0);
    end

endmodule

// File: rtl/vend_multi.sv
// Multi-product vending controller: credit accumulation, per-item vend and
// paced refund. States: IDLE (no credit) | CREDIT (credit held) | REFUND (paying back <=2/cycle).
module vend_multi
    import vend_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int CREDIT_W   = 6,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {6'd6, 6'd5, 6'd4, 6'd4},
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10,
    parameter int AUTO_VEND  = 0,
    localparam int SEL_W     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                restock,
    output logic                drink,
    output logic [SEL_W-1:0]    drink_id,
    output logic [1:0]          back,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] CREDIT = ST_CREDIT;
    localparam logic [1:0] REFUND = ST_REFUND;
    localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

    logic [1:0]          state;
    logic [1:0]          units;
    logic [CREDIT_W:0]   sum, cand, remainder;
    logic                coin_ok, req, sel_in_range, in_stock, vend_ok, dec_valid;
    logic [SEL_W-1:0]    req_sel;
    logic [CREDIT_W-1:0] price_sel;
    logic [1:0]          refund_units;
    logic [N_ITEMS-1:0]  empty;

    always_comb begin
        units        = coin_units(coin);
        sum          = {1'b0, credit} + (CREDIT_W+1)'(units);
        coin_ok      = (sum <= MAX_CREDIT);
        cand         = coin_ok ? sum : {1'b0, credit};
        // With AUTO_VEND an absent request behaves as an implicit request for item 0.
        req          = sel_valid || (AUTO_VEND != 0);
        req_sel      = sel_valid ? sel : '0;
        sel_in_range = (32'(req_sel) < 32'(N_ITEMS));
        price_sel    = sel_in_range ? PRICES[req_sel*CREDIT_W +: CREDIT_W] : '1;
        in_stock     = sel_in_range && !empty[req_sel];
        vend_ok      = req && in_stock && (cand >= {1'b0, price_sel});
        remainder    = cand - {1'b0, price_sel};
        refund_units = (credit > CREDIT_W'(1)) ? 2'd2 : {1'b0, credit[0]};
        dec_valid    = (state != REFUND) && (coin != COIN_CANCEL) && vend_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            drink       <= 1'b0;
            drink_id    <= '0;
            back        <= 2'd0;
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            drink       <= 1'b0;
            drink_id    <= '0;
            back        <= 2'd0;
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            if (state == REFUND) begin
                // busy stays high through the cycle that carries the last refund units.
                back        <= refund_units;
                credit      <= credit - CREDIT_W'(refund_units);
                coin_reject <= (coin == COIN_1) || (coin == COIN_2);
                sel_reject  <= sel_valid;
                busy        <= 1'b1;
                state       <= (credit > CREDIT_W'(2)) ? REFUND : IDLE;
            end else begin
                busy        <= 1'b0;
                coin_reject <= !coin_ok;
                if (coin == COIN_CANCEL) begin
                    if (credit != '0) begin
                        state <= REFUND;
                        busy  <= 1'b1;
                    end
                end else if (vend_ok) begin
                    drink    <= 1'b1;
                    drink_id <= req_sel;
                    credit   <= remainder[CREDIT_W-1:0];
                    state    <= (remainder != '0) ? REFUND : IDLE;
                    busy     <= (remainder != '0);
                end else begin
                    sel_reject <= sel_valid;
                    credit     <= cand[CREDIT_W-1:0];
                    state      <= (cand != '0) ? CREDIT : IDLE;
                end
            end
        end
    end

    vend_stock #(
        .N_ITEMS    (N_ITEMS),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT),
        .SEL_W      (SEL_W)
    ) u_stock (
        .clk       (clk),
        .reset     (reset),
        .dec_valid (dec_valid),
        .dec_idx   (req_sel),
        .restock   (restock),
        .empty     (empty)
    );

endmodule

// File: tb/tb_vend_multi.sv
// Directed bench for vend_multi: expected output records are queued with each
// stimulus step and compared one cycle later; a second instance runs AUTO_VEND.
module tb_vend_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] coin, coin_a;
    logic       sel_valid, sel_valid_a;
    logic [1:0] sel, sel_a;
    logic       restock, restock_a;

    logic       drink, drink_a;
    logic [1:0] drink_id, drink_id_a;
    logic [1:0] back, back_a;
    logic       coin_reject, coin_reject_a;
    logic       sel_reject, sel_reject_a;
    logic       busy, busy_a;
    logic [5:0] credit, credit_a;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic       drink;
        logic [1:0] id;
        logic [1:0] back;
        logic       crej;
        logic       srej;
        logic       busy;
        logic [5:0] credit;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    vend_multi dut (
        .clk(clk), .reset(reset), .coin(coin), .sel_valid(sel_valid), .sel(sel),
        .restock(restock), .drink(drink), .drink_id(drink_id), .back(back),
        .coin_reject(coin_reject), .sel_reject(sel_reject), .busy(busy), .credit(credit)
    );

    vend_multi #(.AUTO_VEND(1)) dut_a (
        .clk(clk), .reset(reset), .coin(coin_a), .sel_valid(sel_valid_a), .sel(sel_a),
        .restock(restock_a), .drink(drink_a), .drink_id(drink_id_a), .back(back_a),
        .coin_reject(coin_reject_a), .sel_reject(sel_reject_a), .busy(busy_a), .credit(credit_a)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic exp_push(input logic d, input logic [1:0] id, input logic [1:0] bk,
                            input logic cr, input logic sr, input logic bz, input logic [5:0] cred);
        exp_t e;
        e.drink = d; e.id = id; e.back = bk; e.crej = cr; e.srej = sr; e.busy = bz; e.credit = cred;
        sbq.push_back(e);
    endtask

    task automatic compare_out(input bit which, input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, ":scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        if (!which) begin
            check({tag, ":drink"},       32'(drink),       32'(e.drink));
            check({tag, ":drink_id"},    32'(drink_id),    32'(e.id));
            check({tag, ":back"},        32'(back),        32'(e.back));
            check({tag, ":coin_reject"}, 32'(coin_reject), 32'(e.crej));
            check({tag, ":sel_reject"},  32'(sel_reject),  32'(e.srej));
            check({tag, ":busy"},        32'(busy),        32'(e.busy));
            check({tag, ":credit"},      32'(credit),      32'(e.credit));
        end else begin
            check({tag, ":a_drink"},       32'(drink_a),       32'(e.drink));
            check({tag, ":a_drink_id"},    32'(drink_id_a),    32'(e.id));
            check({tag, ":a_back"},        32'(back_a),        32'(e.back));
            check({tag, ":a_coin_reject"}, 32'(coin_reject_a), 32'(e.crej));
            check({tag, ":a_sel_reject"},  32'(sel_reject_a),  32'(e.srej));
            check({tag, ":a_busy"},        32'(busy_a),        32'(e.busy));
            check({tag, ":a_credit"},      32'(credit_a),      32'(e.credit));
        end
    endtask

    task automatic idle_inputs();
        coin = 2'd0;   sel_valid = 1'b0;   sel = 2'd0;   restock = 1'b0;
        coin_a = 2'd0; sel_valid_a = 1'b0; sel_a = 2'd0; restock_a = 1'b0;
    endtask

    // Drive one edge's worth of stimulus, then compare against the queued record.
    task automatic step(input bit which, input string tag, input logic [1:0] c,
                        input logic sv, input logic [1:0] s, input logic rs);
        idle_inputs();
        if (!which) begin
            coin = c; sel_valid = sv; sel = s; restock = rs;
        end else begin
            coin_a = c; sel_valid_a = sv; sel_a = s; restock_a = rs;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        compare_out(which, tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":drink"},  32'(drink),       32'd0);
        check({tag, ":id"},     32'(drink_id),    32'd0);
        check({tag, ":back"},   32'(back),        32'd0);
        check({tag, ":crej"},   32'(coin_reject), 32'd0);
        check({tag, ":srej"},   32'(sel_reject),  32'd0);
        check({tag, ":busy"},   32'(busy),        32'd0);
        check({tag, ":credit"}, 32'(credit),      32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #12;
        check_all_zero("reset");
        check("reset:a_credit", 32'(credit_a), 32'd0);
        check("reset:a_busy",   32'(busy_a),   32'd0);
        reset = 1'b0;

        // Exact-price purchase of item 0 (price 4).
        exp_push(0, 0, 0, 0, 0, 0, 6'd2); step(0, "t1_coin", 2'd2, 0, 2'd0, 0);
        exp_push(1, 0, 0, 0, 0, 0, 6'd0); step(0, "t1_vend", 2'd2, 1, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd0); step(0, "t1_after", 2'd0, 0, 2'd0, 0);

        // Item 1 (price 4) with 5 units: one unit of change.
        exp_push(0, 0, 0, 0, 0, 0, 6'd2); step(0, "t2_c1", 2'd2, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd4); step(0, "t2_c2", 2'd2, 0, 2'd0, 0);
        exp_push(1, 1, 0, 0, 0, 1, 6'd1); step(0, "t2_vend", 2'd1, 1, 2'd1, 0);
        exp_push(0, 0, 1, 0, 0, 1, 6'd0); step(0, "t2_back", 2'd0, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd0); step(0, "t2_idle", 2'd0, 0, 2'd0, 0);

        // Cancel with 6 units; a coin during refund is rejected.
        exp_push(0, 0, 0, 0, 0, 0, 6'd2); step(0, "t3_c1", 2'd2, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd4); step(0, "t3_c2", 2'd2, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd6); step(0, "t3_c3", 2'd2, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 1, 6'd6); step(0, "t3_cancel", 2'd3, 0, 2'd0, 0);
        exp_push(0, 0, 2, 0, 0, 1, 6'd4); step(0, "t3_back1", 2'd0, 0, 2'd0, 0);
        exp_push(0, 0, 2, 1, 0, 1, 6'd2); step(0, "t3_back2", 2'd1, 0, 2'd0, 0);
        exp_push(0, 0, 2, 0, 0, 1, 6'd0); step(0, "t3_back3", 2'd0, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd0); step(0, "t3_done", 2'd0, 0, 2'd0, 0);

        // Drain item 2 (price 5), then an out-of-stock refusal and a restock.
        for (int k = 0; k < 10; k++) begin
            exp_push(0, 0, 0, 0, 0, 0, 6'd2); step(0, "t4_c1", 2'd2, 0, 2'd0, 0);
            exp_push(0, 0, 0, 0, 0, 0, 6'd4); step(0, "t4_c2", 2'd2, 0, 2'd0, 0);
            exp_push(1, 2, 0, 0, 0, 0, 6'd0); step(0, "t4_vend", 2'd1, 1, 2'd2, 0);
        end
        exp_push(0, 0, 0, 0, 0, 0, 6'd2); step(0, "t4_e_c1", 2'd2, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd4); step(0, "t4_e_c2", 2'd2, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 1, 0, 6'd5); step(0, "t4_empty", 2'd1, 1, 2'd2, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd5); step(0, "t4_restock", 2'd0, 0, 2'd0, 1);
        exp_push(1, 2, 0, 0, 0, 0, 6'd0); step(0, "t4_revend", 2'd0, 1, 2'd2, 0);

        // Fill to 62, overflow reject, then reset in the middle of a refund.
        for (int k = 1; k <= 31; k++) begin
            exp_push(0, 0, 0, 0, 0, 0, 6'(2 * k)); step(0, "t5_fill", 2'd2, 0, 2'd0, 0);
        end
        exp_push(0, 0, 0, 1, 0, 0, 6'd62); step(0, "t5_ovf", 2'd2, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 1, 6'd62); step(0, "t5_cancel", 2'd3, 0, 2'd0, 0);
        exp_push(0, 0, 2, 0, 0, 1, 6'd60); step(0, "t5_back", 2'd0, 0, 2'd0, 0);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("t5_async_reset");
        #2;
        reset = 1'b0;
        exp_push(0, 0, 0, 0, 0, 0, 6'd0); step(0, "t5_post", 2'd0, 0, 2'd0, 0);

        // AUTO_VEND instance: item 0 vends on the fourth single-unit coin.
        exp_push(0, 0, 0, 0, 0, 0, 6'd1); step(1, "t6_c1", 2'd1, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd2); step(1, "t6_c2", 2'd1, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd3); step(1, "t6_c3", 2'd1, 0, 2'd0, 0);
        exp_push(1, 0, 0, 0, 0, 0, 6'd0); step(1, "t6_vend", 2'd1, 0, 2'd0, 0);
        exp_push(0, 0, 0, 0, 0, 0, 6'd0); step(1, "t6_after", 2'd0, 0, 2'd0, 0);

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
